// File: rtl/uart8_receiver_pkg.sv
// uart8_receiver_pkg: FSM state encodings shared by the UART receiver and transmitter.
package uart8_receiver_pkg;
   typedef enum logic [2:0] {
      IDLE,
      START_BIT,
      DATA_BITS,
      PARITY_BIT,
      STOP_BIT,
      WAIT_IDLE
   } uart_state_t;
endpackage

// File: rtl/uart8_receiver_sync.sv
// uart_rx_sync: metastability synchroniser for the asynchronous rx line, resets to idle-high.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s
);
   logic [SYNC_STAGES-1:0] ff;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '1;
      else begin
         ff[0] <= rx;
         for (int i = 1; i < SYNC_STAGES; i++) ff[i] <= ff[i-1];
      end
   end
   assign rx_s = ff[SYNC_STAGES-1];
endmodule

// File: rtl/uart8_receiver.sv
// uart8_receiver: oversampling 8N1 UART receiver with a one-byte holding buffer.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity_err.
module uart8_receiver
   import uart8_receiver_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       busy,
   output logic       frame_err,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       overrun
);
   localparam int CW = $clog2(OVERSAMPLE);
   uart_state_t state;
   logic [CW-1:0] cnt;
   logic [2:0] idx;
   logic [7:0] sh;
   logic rx_s, mid, half, done;
`ifdef UART_RX_PARITY_EN
   logic par_bad;
`endif

   uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .rx(rx), .rx_s(rx_s));

   assign mid  = cnt == CW'(OVERSAMPLE - 1);
   assign half = cnt == CW'(OVERSAMPLE / 2 - 1);
   assign done = en && state == STOP_BIT && mid && rx_s;
   assign busy = state != IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         sh        <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
         par_bad    <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (done && (!valid || ready)) begin
            data  <= sh;
            valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
         end else if (done) overrun <= 1'b1;
         else if (valid && ready) valid <= 1'b0;
         if (en) begin
            cnt <= cnt + CW'(1);
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (!rx_s) state <= START_BIT;
               end
               START_BIT: if (half) begin
                  cnt   <= '0;
                  state <= rx_s ? IDLE : DATA_BITS;
               end
               DATA_BITS: if (mid) begin
                  cnt <= '0;
                  sh  <= {rx_s, sh[7:1]};
                  idx <= idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (idx == 3'd7) state <= PARITY_BIT;
`else
                  if (idx == 3'd7) state <= STOP_BIT;
`endif
               end
`ifdef UART_RX_PARITY_EN
               PARITY_BIT: if (mid) begin
                  cnt     <= '0;
                  par_bad <= rx_s ^ (^sh);
                  state   <= STOP_BIT;
               end
`endif
               STOP_BIT: if (mid) begin
                  cnt       <= '0;
                  state     <= rx_s ? IDLE : WAIT_IDLE;
                  frame_err <= !rx_s;
               end
               WAIT_IDLE: if (rx_s) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart8_receiver.sv
// tb_uart8_receiver: directed frames against uart8_receiver; en ticks every 4th clk.
module tb_uart8_receiver;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, rx = 1'b1, ready = 1'b1;
   logic [7:0] data;
   logic valid, busy, frame_err, overrun;
   int checks = 0, passes = 0;
   int n_acc = 0, n_vhi = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
   logic [7:0] last_acc = 8'h00;
`ifdef UART_RX_PARITY_EN
   logic parity_err;
`endif

   uart8_receiver dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rx(rx), .data(data), .valid(valid), .ready(ready),
      .busy(busy), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err(parity_err),
`endif
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) n_vhi++;
      if (valid && ready) begin
         n_acc++;
         last_acc = data;
      end
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_perr++;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic b, input int n);
      rx = b;
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] d, input logic par, input logic stop);
      hold(1'b0, 16);
      for (int i = 0; i < 8; i++) hold(d[i], 16);
`ifdef UART_RX_PARITY_EN
      hold(par, 16);
`else
      if (par) rx = 1'b1;
`endif
      hold(stop, 16);
      if (stop) hold(1'b1, 4);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", data, 8'h00);
      chk("rst_valid", valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      hold(1'b1, 4);

      send(8'hA5, 1'b0, 1'b1);
      chk("a5_acc", n_acc, 1);
      chk("a5_data", last_acc, 8'hA5);
      chk("a5_valid_1clk", n_vhi, 1);
      chk("a5_ferr", n_ferr, 0);
      chk("a5_ovr", n_ovr, 0);

      hold(1'b0, 4);
      hold(1'b1, 12);
      chk("glitch_busy", busy, 1'b0);
      chk("glitch_acc", n_acc, 1);
      chk("glitch_ferr", n_ferr, 0);

      send(8'h3C, 1'b0, 1'b0);
      hold(1'b0, 8);
      chk("ferr_cnt", n_ferr, 1);
      chk("ferr_busy", busy, 1'b1);
      chk("ferr_acc", n_acc, 1);
      hold(1'b1, 4);
      chk("ferr_idle", busy, 1'b0);

      ready = 1'b0;
      send(8'h11, 1'b0, 1'b1);
      chk("ovr_valid", valid, 1'b1);
      chk("ovr_data1", data, 8'h11);
      send(8'h22, 1'b0, 1'b1);
      chk("ovr_pulse", n_ovr, 1);
      chk("ovr_data2", data, 8'h11);
      ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ovr_acc", n_acc, 2);
      chk("ovr_acc_data", last_acc, 8'h11);
      chk("ovr_cleared", valid, 1'b0);

      hold(1'b0, 16);
      hold(1'b1, 56);
      chk("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mr_busy", busy, 1'b0);
      chk("mr_data", data, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      hold(1'b1, 20);
      chk("mr_noacc", n_acc, 2);
      send(8'h00, 1'b0, 1'b1);
      chk("mr_acc", n_acc, 3);
      chk("mr_data0", last_acc, 8'h00);
      chk("mr_ferr", n_ferr, 1);
      chk("mr_ovr", n_ovr, 1);

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b0, 1'b1);
      chk("par_bad_acc", n_acc, 4);
      chk("par_bad_data", last_acc, 8'h07);
      chk("par_bad_pulse", n_perr, 1);
      send(8'h07, 1'b1, 1'b1);
      chk("par_ok_acc", n_acc, 5);
      chk("par_ok_pulse", n_perr, 1);
`else
      chk("no_parity_pulse", n_perr, 0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
